// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Access-type codes follow the RISC-V load/store funct3 field.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_F,
        BUSY_D
    } arb_state_t;

    typedef enum logic [1:0] {
        ARB_OWNER_NONE = 2'd0,
        ARB_OWNER_F    = 2'd1,
        ARB_OWNER_D    = 2'd2
    } arb_owner_t;

    localparam logic [2:0] ACC_LB  = 3'b000;
    localparam logic [2:0] ACC_LH  = 3'b001;
    localparam logic [2:0] ACC_LW  = 3'b010;
    localparam logic [2:0] ACC_LBU = 3'b100;
    localparam logic [2:0] ACC_LHU = 3'b101;
    localparam logic [2:0] ACC_SB  = 3'b000;
    localparam logic [2:0] ACC_SH  = 3'b001;
    localparam logic [2:0] ACC_SW  = 3'b010;

    localparam int CNT_W = 4;

    function automatic arb_owner_t owner_of(input arb_state_t s);
        unique case (s)
            BUSY_F:  return ARB_OWNER_F;
            BUSY_D:  return ARB_OWNER_D;
            default: return ARB_OWNER_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Priority decision between fetch and data requesters.
// Data wins unless its streak has reached the limit while fetch waits.
module arb_pick (
    input  logic f_req,
    input  logic d_req,
    input  logic streak_at_max,
    output logic grant_f,
    output logic grant_d
);

    logic take_d;

    assign take_d  = d_req & ~(f_req & streak_at_max);
    assign grant_d = take_d;
    assign grant_f = f_req & ~take_d;

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for fetch and load/store traffic.
// One access in flight; re-arbitrates in the response cycle.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AWIDTH          = 32,
    parameter int DWIDTH          = 32,
    parameter int MEM_LATENCY     = 1,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req_i,
    input  logic [AWIDTH-1:0] f_addr_i,
    input  logic              f_flush_i,
    output logic              f_gnt_o,
    output logic              f_rsp_valid_o,
    output logic [DWIDTH-1:0] f_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [AWIDTH-1:0] d_addr_i,
    input  logic [DWIDTH-1:0] d_wdata_i,
    input  logic [2:0]        d_size_i,
    output logic              d_gnt_o,
    output logic              d_rsp_valid_o,
    output logic [DWIDTH-1:0] d_rdata_o,
    output logic              mem_re_o,
    output logic              mem_we_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_wdata_o,
    output logic [2:0]        mem_size_o,
    input  logic [DWIDTH-1:0] mem_rdata_i
);

    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] SMAX     = CNT_W'(MAX_DATA_STREAK);

    arb_state_t       state;
    arb_state_t       state_nxt;
    arb_owner_t       owner;
    logic [CNT_W-1:0] lat_cnt;
    logic [CNT_W-1:0] lat_nxt;
    logic [CNT_W-1:0] streak;
    logic [CNT_W-1:0] streak_nxt;
    logic             drop;
    logic             drop_nxt;
    logic             store_q;
    logic             store_nxt;

    logic rsp_cycle;
    logic arb_en;
    logic streak_at_max;
    logic pick_f;
    logic pick_d;
    logic gnt_f;
    logic gnt_d;
    logic flush_hit;

    assign owner         = owner_of(state);
    assign rsp_cycle     = !reset && (state != IDLE) && (lat_cnt == '0);
    assign arb_en        = !reset && ((state == IDLE) || rsp_cycle);
    assign streak_at_max = (streak == SMAX);
    assign flush_hit     = (state == BUSY_F) && f_flush_i;

    arb_pick u_pick (
        .f_req         (f_req_i),
        .d_req         (d_req_i),
        .streak_at_max (streak_at_max),
        .grant_f       (pick_f),
        .grant_d       (pick_d)
    );

    assign gnt_f = arb_en & pick_f;
    assign gnt_d = arb_en & pick_d;

    // Memory side: strobes and buses carry only the winner, only on issue.
    always_comb begin
        f_gnt_o     = gnt_f;
        d_gnt_o     = gnt_d;
        mem_re_o    = gnt_f | (gnt_d & ~d_we_i);
        mem_we_o    = gnt_d & d_we_i;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_size_o  = '0;
        unique case (1'b1)
            gnt_f: begin
                mem_addr_o = f_addr_i;
                mem_size_o = ACC_LW;
            end
            gnt_d: begin
                mem_addr_o  = d_addr_i;
                mem_wdata_o = d_wdata_i;
                mem_size_o  = d_size_i;
            end
            default: ;
        endcase
    end

    // A flush in the response cycle itself still kills the stale fetch.
    always_comb begin
        f_rsp_valid_o = rsp_cycle && (owner == ARB_OWNER_F)
                        && !drop && !f_flush_i;
        d_rsp_valid_o = rsp_cycle && (owner == ARB_OWNER_D);
        f_rdata_o     = f_rsp_valid_o ? mem_rdata_i : '0;
        d_rdata_o     = (d_rsp_valid_o && !store_q) ? mem_rdata_i : '0;
    end

    always_comb begin
        state_nxt  = state;
        lat_nxt    = lat_cnt;
        drop_nxt   = drop;
        store_nxt  = store_q;
        streak_nxt = streak;
        if (gnt_f || gnt_d) begin
            state_nxt = gnt_f ? BUSY_F : BUSY_D;
            lat_nxt   = LAT_INIT;
            drop_nxt  = 1'b0;
            store_nxt = gnt_d & d_we_i;
        end else if (rsp_cycle) begin
            state_nxt = IDLE;
            drop_nxt  = 1'b0;
            store_nxt = 1'b0;
        end else if (state != IDLE) begin
            lat_nxt = lat_cnt - 1'b1;
            if (flush_hit) begin
                drop_nxt = 1'b1;
            end
        end
        if (gnt_f) begin
            streak_nxt = '0;
        end else if (gnt_d) begin
            if (!f_req_i) begin
                streak_nxt = '0;
            end else if (!streak_at_max) begin
                streak_nxt = streak + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            lat_cnt <= '0;
            streak  <= '0;
            drop    <= 1'b0;
            store_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_nxt;
            streak  <= streak_nxt;
            drop    <= drop_nxt;
            store_q <= store_nxt;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified memory between two requesters: instruction fetch and the data path (loads/stores driven by the decode control bits memren/memwren and memReadType/memWriteType).
- Sits between the fetch/memory stages and the memory model.
- Issues at most one access at a time and tracks the fixed memory latency.
- Returns responses to the owning requester.
- Data requests have priority, with a starvation guard for fetch.

Parameters:
- AWIDTH, 32, address width.
- DWIDTH, 32, data width.
- MEM_LATENCY, 1, cycles from issue to read data/write completion; legal range 1 to 15.
- MAX_DATA_STREAK, 4, maximum consecutive data grants while fetch waits; legal range 1 to 15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- f_req_i  in  1  fetch request; held with f_addr_i until f_gnt_o
- f_addr_i  in  AWIDTH  fetch address (word read)
- f_flush_i  in  1  discard outstanding fetch response (redirect)
- f_gnt_o  out  1  fetch request issued this cycle
- f_rsp_valid_o  out  1  fetch data valid, one-cycle pulse
- f_rdata_o  out  DWIDTH  fetch data
- d_req_i  in  1  data request; held stable until d_gnt_o
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  AWIDTH  data address
- d_wdata_i  in  DWIDTH  store data
- d_size_i  in  3  funct3 access type (LB/LH/LW/LBU/LHU, SB/SH/SW)
- d_gnt_o  out  1  data request issued this cycle
- d_rsp_valid_o  out  1  load data valid / store complete, one-cycle pulse
- d_rdata_o  out  DWIDTH  load data; 0 for stores
- mem_re_o  out  1  memory read strobe
- mem_we_o  out  1  memory write strobe
- mem_addr_o  out  AWIDTH  memory address
- mem_wdata_o  out  DWIDTH  memory write data
- mem_size_o  out  3  memory access type
- mem_rdata_i  in  DWIDTH  memory read data, valid MEM_LATENCY cycles after issue

Behaviour:
- Reset:
  - Synchronous, active-high, single clock clk.
  - State IDLE; lat_cnt = 0; streak = 0; owner = NONE.
  - Every output is 0, including all *_o data buses.
- States:
  - IDLE: no access outstanding.
  - BUSY_F: fetch access outstanding.
  - BUSY_D: data access outstanding.
- Arbitration:
  - Evaluated combinationally in IDLE, and in the response cycle of BUSY_* (back-to-back issue allowed).
  - Pick rule:
    - Only d_req_i set: data.
    - Only f_req_i set: fetch.
    - Both set: data, unless streak == MAX_DATA_STREAK, then fetch.
- Issue cycle:
  - Exactly one of f_gnt_o/d_gnt_o is 1.
  - mem_re_o/mem_we_o, mem_addr_o, mem_wdata_o and mem_size_o are driven combinationally from the winner's inputs.
  - Fetch issues mem_size_o = 3'b010 (LW) and mem_we_o = 0.
  - Next state is BUSY_F or BUSY_D; lat_cnt is loaded with MEM_LATENCY-1.
- Memory strobes and buses are 0 in every non-issue cycle.
- BUSY_*:
  - lat_cnt decrements each cycle.
  - The cycle with lat_cnt == 0 is the response cycle, i.e. issue + MEM_LATENCY.
  - In that cycle the owner's rsp_valid pulses with rdata = mem_rdata_i (d_rdata_o = 0 for a store).
  - Then re-arbitrate; go to IDLE if there is no request.
- Streak counter:
  - Increments on a data grant while f_req_i = 1, saturating at MAX_DATA_STREAK.
  - Clears on any fetch grant, or when f_req_i = 0 at a data grant.
- Flush:
  - f_flush_i in any cycle while BUSY_F, including its response cycle, sets a drop flag.
  - With the drop flag set, the fetch response is suppressed (f_rsp_valid_o = 0); the memory access still completes its latency.
  - The flag clears when BUSY_F exits.
  - f_flush_i has no effect in IDLE/BUSY_D.
  - A same-cycle fetch grant is not affected by the flush; the new request is the post-redirect one.
- Requests must not be dropped by the requester before grant; arbiter behaviour is undefined otherwise.
- No pipelining: at most one access outstanding.
- Peak throughput is one access per MEM_LATENCY cycles.
- Reset asserted mid-access: the outstanding access is abandoned, no rsp_valid is produced, and the state returns to IDLE at the next edge.
- Simultaneous reset and requests: reset wins; no grant.

Decomposition:
- Shared package (constants.svh):
  - arb_state_t enum {IDLE, BUSY_F, BUSY_D}.
  - Access-type constants for LB/LH/LW/LBU/LHU/SB/SH/SW, matching funct3.
  - ARB_OWNER_F/ARB_OWNER_D encodings.
- One natural sub-module, arb_pick: a combinational priority/streak decision taking f_req, d_req and streak_at_max, and producing grant_f and grant_d.
- Counters and FSM stay in mem_port_arbiter.

Test Plan:
1. MEM_LATENCY = 1; f_req only, addr 0x01000000 -> f_gnt_o in cycle 0, mem_re_o = 1, mem_size_o = 3'b010; f_rsp_valid_o in cycle 1 with f_rdata_o = mem_rdata_i = 0x00500093.
2. f_req and d_req together, d load 0x01000100 size LW -> d_gnt_o first; d_rsp_valid_o at +1; f_gnt_o in that same response cycle; f_rsp_valid_o at +2.
3. f_req held and d_req held for 10 accesses, MAX_DATA_STREAK = 4 -> grant order D,D,D,D,F,D,D,D,D,F.
4. MEM_LATENCY = 3; store SW 0xDEADBEEF to 0x01000200 -> mem_we_o = 1 for 1 cycle only; d_rsp_valid_o exactly 3 cycles later with d_rdata_o = 0; no read strobe.
5. MEM_LATENCY = 3; fetch issued, f_flush_i pulsed at issue+1 -> no f_rsp_valid_o; next fetch grant not earlier than issue+3.
6. Load outstanding, MEM_LATENCY = 3; reset at issue+1 -> all outputs 0 next cycle; no d_rsp_valid_o; IDLE; first grant after reset is taken normally.
